// File: rtl/cpu_controller.sv
// Multicycle control FSM for the simple datapath CPU.
// Holds the instruction register and sequences the datapath strobes.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B,
    S_ALU, S_WRITE_REG, S_WRITE_IMM, S_STATUS
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic       w_q, w_d;
  logic [2:0] readnum_q, readnum_d;
  logic [2:0] writenum_q, writenum_d;
  logic       loada_q, loada_d;
  logic       loadb_q, loadb_d;
  logic       loadc_q, loadc_d;
  logic       loads_q, loads_d;
  logic       write_q, write_d;
  logic       asel_q, asel_d;
  logic [1:0] vsel_q, vsel_d;
  logic [1:0] shift_q, shift_d;
  logic [1:0] aluop_q, aluop_d;

  logic [2:0] opc;
  logic [1:0] op;
  logic       is_movi, is_movr, is_mvn, is_alu3, is_cmp;

  assign opc     = ir_d[15:13];
  assign op      = ir_d[12:11];
  assign is_movi = (opc == 3'b110) && (op == 2'b10);
  assign is_movr = (opc == 3'b110) && (op == 2'b00);
  assign is_mvn  = (opc == 3'b101) && (op == 2'b11);
  assign is_alu3 = (opc == 3'b101) && (op != 2'b11);
  assign is_cmp  = (opc == 3'b101) && (op == 2'b01);

  // IR only changes in WAIT, so decoding ir_d is valid in every state
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_WAIT && load) ir_d = in;
    state_d = state_q;
    unique case (state_q)
      S_WAIT:   if (s) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_movi:          state_d = S_WRITE_IMM;
          is_movr, is_mvn:  state_d = S_GET_B;
          is_alu3:          state_d = S_GET_A;
          default:          state_d = S_WAIT;
        endcase
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = is_cmp ? S_STATUS : S_ALU;
      S_ALU:    state_d = S_WRITE_REG;
      default:  state_d = S_WAIT;
    endcase
  end

  // outputs are registered from the next state so they stay Moore
  always_comb begin
    w_d        = 1'b0;
    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    write_d    = 1'b0;
    asel_d     = 1'b0;
    vsel_d     = 2'b00;
    shift_d    = 2'b00;
    aluop_d    = 2'b00;
    unique case (state_d)
      S_WAIT:   w_d = 1'b1;
      S_GET_A: begin
        readnum_d = ir_d[10:8];
        loada_d   = 1'b1;
      end
      S_GET_B: begin
        readnum_d = ir_d[2:0];
        loadb_d   = 1'b1;
      end
      S_ALU: begin
        loadc_d = 1'b1;
        asel_d  = is_movr | is_mvn;
        shift_d = ir_d[4:3];
        aluop_d = is_movr ? 2'b00 : op;
      end
      S_STATUS: begin
        loads_d = 1'b1;
        shift_d = ir_d[4:3];
        aluop_d = 2'b01;
      end
      S_WRITE_REG: begin
        write_d    = 1'b1;
        writenum_d = ir_d[7:5];
      end
      S_WRITE_IMM: begin
        write_d    = 1'b1;
        writenum_d = ir_d[10:8];
        vsel_d     = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT;
      ir_q       <= 16'h0000;
      w_q        <= 1'b1;
      readnum_q  <= 3'd0;
      writenum_q <= 3'd0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      write_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= 2'b00;
      shift_q    <= 2'b00;
      aluop_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      w_q        <= w_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      write_q    <= write_d;
      asel_q     <= asel_d;
      vsel_q     <= vsel_d;
      shift_q    <= shift_d;
      aluop_q    <= aluop_d;
    end
  end

  assign w        = w_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign write    = write_q;
  assign asel     = asel_q;
  assign bsel     = 1'b0;
  assign vsel     = vsel_q;
  assign shift    = shift_q;
  assign ALUop    = aluop_q;
  assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: per-instruction step plans as the model,
// directed instruction checks plus randomized stimulus.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1, s = 1'b0, load = 1'b0;
  logic [15:0] din = 16'h0;
  logic        w, loada, loadb, loadc, loads, write, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(din),
    .w(w), .readnum(readnum), .writenum(writenum),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .write(write), .asel(asel), .bsel(bsel), .vsel(vsel),
    .shift(shift), .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model: IR copy plus a queue of remaining per-cycle output steps
  logic [15:0] m_ir = 16'h0;
  logic [19:0] plan[$];

  function automatic logic [19:0] mk(
    input logic w_, input logic [2:0] rdn, input logic [2:0] wrn,
    input logic la, input logic lb, input logic lc, input logic ls,
    input logic wr, input logic as, input logic [1:0] vs,
    input logic [1:0] sh, input logic [1:0] op);
    return {w_, rdn, wrn, la, lb, lc, ls, wr, as, 1'b0, vs, sh, op};
  endfunction

  task automatic build_plan(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    plan.push_back(20'h0);
    if (opc == 3'b110 && op == 2'b10) begin
      plan.push_back(mk(0, 0, rn, 0, 0, 0, 0, 1, 0, 2'b01, 0, 0));
    end else if ((opc == 3'b110 && op == 2'b00) ||
                 (opc == 3'b101 && op == 2'b11)) begin
      plan.push_back(mk(0, rm, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, sh,
                        (opc == 3'b110) ? 2'b00 : 2'b11));
      plan.push_back(mk(0, 0, rd, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    end else if (opc == 3'b101) begin
      plan.push_back(mk(0, rn, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      plan.push_back(mk(0, rm, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      if (op == 2'b01) begin
        plan.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, sh, 2'b01));
      end else begin
        plan.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, sh, op));
        plan.push_back(mk(0, 0, rd, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic step(input logic r, input logic ss, input logic ld,
                      input logic [15:0] d);
    logic [19:0] e;
    logic [51:0] exp_v, act_v;
    reset = r; s = ss; load = ld; din = d;
    @(posedge clk);
    if (r) begin
      m_ir = 16'h0;
      plan.delete();
    end else if (plan.size() == 0) begin
      if (ld) m_ir = d;
      if (ss) build_plan(m_ir);
    end else begin
      void'(plan.pop_front());
    end
    @(negedge clk);
    e = (plan.size() != 0) ? plan[0]
                           : mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_v = {e, {{11{m_ir[4]}}, m_ir[4:0]}, {{8{m_ir[7]}}, m_ir[7:0]}};
    act_v = {w, readnum, writenum, loada, loadb, loadc, loads, write,
             asel, bsel, vsel, shift, ALUop, sximm5, sximm8};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL model t=%0t: dut=%h expected=%h", $time, act_v, exp_v);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp_);
    vectors++;
    if (act != exp_) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_);
    end
  endtask

  int lat, wr_cnt, ls_cnt, la_cnt, rd_a, rd_b, wn, vs;
  int a_op, a_sh, a_as, l_sh, l_op;

  task automatic note();
    if (loada) begin la_cnt++; rd_a = int'(readnum); end
    if (loadb) rd_b = int'(readnum);
    if (loadc) begin
      a_op = int'(ALUop); a_sh = int'(shift); a_as = int'(asel);
    end
    if (loads) begin
      ls_cnt++; l_sh = int'(shift); l_op = int'(ALUop);
    end
    if (write) begin
      wr_cnt++; wn = int'(writenum); vs = int'(vsel);
    end
  endtask

  task automatic run_instr(input logic [15:0] d);
    lat = 0; wr_cnt = 0; ls_cnt = 0; la_cnt = 0;
    rd_a = 9; rd_b = 9; wn = 9; vs = 9;
    a_op = 9; a_sh = 9; a_as = 9; l_sh = 9; l_op = 9;
    step(0, 1, 1, d);
    lat = 1;
    note();
    while (!w && lat < 20) begin
      step(0, 0, 0, 16'h0);
      lat++;
      note();
    end
    if (!w) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: w=%b after %0d cycles, expected 1", w, lat);
    end
  endtask

  initial begin
    logic [15:0] d;
    step(1, 1, 1, 16'hFFFF);
    step(1, 0, 0, 16'h0);
    chk("rst_w", int'(w), 1);
    chk("rst_sximm5", int'(sximm5), 0);

    run_instr(16'hD105);
    chk("movi_lat", lat, 3);
    chk("movi_wr_cnt", wr_cnt, 1);
    chk("movi_writenum", wn, 1);
    chk("movi_vsel", vs, 1);
    chk("movi_sximm8", int'(sximm8), 5);

    run_instr(16'hA140);
    chk("add_lat", lat, 6);
    chk("add_rd_a", rd_a, 1);
    chk("add_rd_b", rd_b, 0);
    chk("add_aluop", a_op, 0);
    chk("add_asel", a_as, 0);
    chk("add_writenum", wn, 2);
    chk("add_vsel", vs, 0);

    run_instr(16'hA908);
    chk("cmp_lat", lat, 5);
    chk("cmp_rd_a", rd_a, 1);
    chk("cmp_rd_b", rd_b, 0);
    chk("cmp_loads_cnt", ls_cnt, 1);
    chk("cmp_shift", l_sh, 1);
    chk("cmp_aluop", l_op, 1);
    chk("cmp_wr_cnt", wr_cnt, 0);

    run_instr(16'hB874);
    chk("mvn_lat", lat, 5);
    chk("mvn_loada_cnt", la_cnt, 0);
    chk("mvn_rd_b", rd_b, 4);
    chk("mvn_aluop", a_op, 3);
    chk("mvn_shift", a_sh, 2);
    chk("mvn_asel", a_as, 1);
    chk("mvn_writenum", wn, 3);
    chk("mvn_sximm5", int'(sximm5), 16'hFFF4);

    step(0, 1, 1, 16'hA140);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    chk("midadd_loadc", int'(loadc), 1);
    step(1, 0, 0, 16'h0);
    chk("midadd_w", int'(w), 1);
    chk("midadd_write", int'(write), 0);
    chk("midadd_sximm8", int'(sximm8), 0);
    step(0, 0, 0, 16'h0);
    chk("midadd_write2", int'(write), 0);

    run_instr(16'hE000);
    chk("ill_lat", lat, 2);
    chk("ill_strobes", wr_cnt + ls_cnt + la_cnt, 0);
    step(0, 1, 1, 16'hE000);
    step(0, 0, 1, 16'hD1FF);
    chk("ill_busy_load", int'(sximm8), 0);

    for (int i = 0; i < 600; i++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       d[15:13] = 3'b110;
        1, 2:    d[15:13] = 3'b101;
        default: ;
      endcase
      step(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 clk  input  1  — Single clock; all state changes on the rising edge.
REQ-002 reset  input  1  — Synchronous, active-high reset.
REQ-003 s  input  1  — Start; sampled only in state WAIT.
REQ-004 load  input  1  — Instruction-register load enable.
REQ-005 in  input  16  — Instruction word.
REQ-006 w  output  1  — Idle indicator; 1 only in state WAIT.
REQ-007 readnum, writenum  output  3 each  — Register file read and write indices.
REQ-008 loada, loadb, loadc, loads, write  output  1 each  — Datapath load and write strobes.
REQ-009 asel, bsel  output  1 each  — Operand selects; 1 selects zero for A and sximm5 for B.
REQ-010 vsel  output  2  — Writeback source: 00 C, 01 sximm8, 10 mdata, 11 reserved and never driven.
REQ-011 shift, ALUop  output  2 each  — Shifter and ALU controls.
REQ-012 sximm5, sximm8  output  16 each  — Sign-extended immediates.

Function
REQ-013 The 16-bit instruction register (IR) SHALL load `in` on a rising edge where load=1 and state=WAIT; load is ignored in every other state.
REQ-014 IR field decode SHALL be: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-015 Immediates SHALL be sximm8={8{IR[7]},IR[7:0]} and sximm5={11{IR[4]},IR[4:0]}, both continuously driven from IR.
REQ-016 The state machine SHALL have states WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM and STATUS.
REQ-017 WAIT SHALL go to DECODE when s=1, otherwise hold; if load=1 and s=1 on the same edge, execution SHALL use the newly loaded IR.
REQ-018 DECODE SHALL branch as follows:
- opcode=110, op=10 (MOV imm) → WRITE_IMM.
- opcode=110, op=00 (MOV reg) → GET_B.
- opcode=101, op=11 (MVN) → GET_B.
- opcode=101, op∈{00,01,10} (ADD, CMP, AND) → GET_A.
- any other encoding → WAIT, with no strobe asserted.
REQ-019 GET_A SHALL drive readnum=Rn and loada=1, then go to GET_B.
REQ-020 GET_B SHALL drive readnum=Rm and loadb=1, then go to STATUS for CMP and to ALU otherwise.
REQ-021 ALU SHALL drive loadc=1, bsel=0 and shift=sh, then go to WRITE_REG.
- asel=1 for MOV reg and MVN; asel=0 otherwise.
- ALUop=00 for MOV reg; ALUop=op for 101-class instructions.
REQ-022 STATUS SHALL drive loads=1, asel=0, bsel=0, shift=sh and ALUop=01, then go to WAIT; write SHALL stay 0 throughout a CMP.
REQ-023 WRITE_REG SHALL drive write=1, writenum=Rd and vsel=00, then go to WAIT.
REQ-024 WRITE_IMM SHALL drive write=1, writenum=Rn and vsel=01, then go to WAIT.
REQ-025 All outputs SHALL be Moore (functions of state and IR only), and every strobe not listed for a state SHALL be 0.
REQ-026 readnum, writenum, shift, ALUop and vsel SHALL be 0 in states that do not specify them.
REQ-027 Latency from the edge sampling s=1 to w=1 SHALL be:
- MOV imm: 3 cycles.
- MOV reg and MVN: 5 cycles.
- ADD and AND: 6 cycles.
- CMP: 5 cycles.
- illegal encoding: 2 cycles.
REQ-028 write SHALL be 1 for exactly one cycle per writing instruction, and loads SHALL be 1 for exactly one cycle per CMP.

Reset
REQ-029 On a rising edge with reset=1, state SHALL become WAIT and IR SHALL become 16'h0000; reset SHALL override s and load.
REQ-030 After reset, w=1, every strobe=0, sximm5=sximm8=0, and all index and select outputs SHALL be 0.
REQ-031 Reset asserted mid-instruction SHALL abort it: no write or loads strobe is issued on any cycle after the reset edge.

Verification
REQ-032 The bench SHALL cover MOV imm: load in=16'hD105 with s=1 → DECODE, then WRITE_IMM with write=1, writenum=1, vsel=01, sximm8=16'h0005 → w=1 three cycles after the s edge.
REQ-033 The bench SHALL cover ADD R2,R1,R0: in=16'hA140 → loada with readnum=1, then loadb with readnum=0, then loadc with ALUop=00, asel=0, bsel=0, then write with writenum=2, vsel=00; w=1 after 6 cycles.
REQ-034 The bench SHALL cover CMP with shift: in=16'hA908 → readnum 1 then readnum 0, then loads=1 with shift=01 and ALUop=01; write=0 in every cycle.
REQ-035 The bench SHALL cover MVN R3,R4,sh=10: in=16'hB874 → loada never asserted; loadb with readnum=4; loadc with ALUop=11, shift=10, asel=1; write with writenum=3.
REQ-036 The bench SHALL cover reset mid-ADD: reset=1 during the ALU cycle → next cycle w=1 and write=0; IR reads 0, so sximm8=0.
REQ-037 The bench SHALL cover an illegal encoding: in=16'hE000 with s=1 → DECODE then WAIT; no strobe asserted; load attempted while busy leaves IR unchanged.
